// File: rtl/corescore_receiver_uart_pkg.sv
// Shared types for the corescore UART receiver.
package corescore_receiver_uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/corescore_receiver_uart_if.sv
// Byte stream from the UART receiver to its consumer (valid/ready).
interface corescore_receiver_uart_if;
  import corescore_receiver_uart_pkg::*;

  logic [BYTE_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/corescore_rx_sync.sv
// Two-flop synchroniser for a single asynchronous input.
module corescore_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Two back-to-back flops; both come out of reset at the idle level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/corescore_receiver_uart.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | line idle, waiting for a low level on rxs
// START      | verifying the start bit at its midpoint
// DATA       | sampling 8 data bits mid-bit, LSB first
// STOP       | sampling the stop bit at its midpoint
// WAIT_IDLE  | framing error seen, waiting for the line to go high
module corescore_receiver_uart
  import corescore_receiver_uart_pkg::*;
#(
  parameter int clk_freq_hz = 25_000_000,
  parameter int baud_rate   = 57600
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_uart_rx,
  corescore_receiver_uart_if.master rx_bus,
  output logic                      o_frame_err,
  output logic                      o_overrun
);

  localparam int DIV  = (clk_freq_hz + baud_rate / 2) / baud_rate;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("corescore_receiver_uart: clocks per bit must be at least 4");
    end
  endgenerate

  logic              rxs;
  rx_state_t         state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] data_q;
  logic              valid_q;

  corescore_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_uart_rx),
    .o_q     (rxs)
  );

  assign rx_bus.o_data  = data_q;
  assign rx_bus.o_valid = valid_q;

  // Frame FSM, baud counter and output buffer; all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      cnt         <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

      if (valid_q && rx_bus.i_ready) begin
        valid_q <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (cnt == CNT_MID) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            shreg[bit_idx] <= rxs;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              // Return mid-stop-bit so a back-to-back start edge is caught.
              state <= ST_IDLE;
              if (!valid_q || rx_bus.i_ready) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
              state       <= ST_WAIT_IDLE;
            end
          end
        end

        ST_WAIT_IDLE: begin
          cnt <= '0;
          if (rxs) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corescore_receiver_uart.sv
// Self-checking bench for corescore_receiver_uart at default rates.
module tb_corescore_receiver_uart;

  localparam int CLK_HZ  = 25_000_000;
  localparam int BAUD    = 57600;
  localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF    = DIV / 2;
  localparam int EXP_LAT = 9 * DIV + HALF + 3;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_uart_rx = 1'b1;
  logic o_frame_err;
  logic o_overrun;

  corescore_receiver_uart_if bus ();

  corescore_receiver_uart #(
    .clk_freq_hz (CLK_HZ),
    .baud_rate   (BAUD)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_uart_rx   (i_uart_rx),
    .rx_bus      (bus),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #20 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, got_cnt = 0;
  int rise_cyc = 0, start_cyc = 0;
  int valid_run = 0, last_run = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         per;
    bit         stop_ok;
    int         exp_ferr;
    bit         chk_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge i_clk) cyc++;

  // Output monitor and scoreboard consumer.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_frame_err) ferr_cnt++;
      if (o_overrun) ovr_cnt++;
      if (o_frame_err && o_overrun) both_cnt++;
      if (bus.o_valid && !prev_valid) rise_cyc = cyc;
      if (bus.o_valid) valid_run++;
      else if (valid_run > 0) begin
        last_run = valid_run;
        valid_run = 0;
      end
      prev_valid = bus.o_valid;
      if (bus.o_valid && bus.i_ready) begin
        got_cnt++;
        if (exp_q.size() == 0) check("unexpected_byte", int'(bus.o_data), -1);
        else check("rx_byte", int'(bus.o_data), int'(exp_q.pop_front()));
      end
    end else begin
      prev_valid = 1'b0;
      valid_run = 0;
    end
  end

  task automatic drive_bit(input logic b, input int per);
    i_uart_rx = b;
    repeat (per) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int per, input bit stop_ok);
    @(posedge i_clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(b[i], per);
    drive_bit(stop_ok, per);
    i_uart_rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 * DIV && exp_q.size() != 0; i++) @(negedge i_clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_data"}, int'(bus.o_data), 0);
    check({name, "_valid"}, int'(bus.o_valid), 0);
    check({name, "_ferr"}, int'(o_frame_err), 0);
    check({name, "_ovr"}, int'(o_overrun), 0);
  endtask

  initial begin
    repeat (90_000) @(posedge i_clk);
    $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0, o0, g0;
    bus.i_ready = 1'b1;

    vecs[0] = '{8'h55, DIV,     1'b1, 0, 1'b1};
    vecs[1] = '{8'hA3, DIV,     1'b1, 0, 1'b1};
    vecs[2] = '{8'h7E, DIV,     1'b0, 1, 1'b0};
    vecs[3] = '{8'h10, DIV,     1'b1, 0, 1'b1};
    vecs[4] = '{8'h00, DIV - 9, 1'b1, 0, 1'b0};
    vecs[5] = '{8'hFF, DIV + 9, 1'b1, 0, 1'b0};

    repeat (4) @(posedge i_clk);
    #1;
    check_idle_outputs("reset");
    i_rst_n = 1'b1;
    repeat (DIV) @(posedge i_clk);
    #1;
    check_idle_outputs("post_reset");

    // Table-driven single frames.
    for (int v = 0; v < 6; v++) begin
      f0 = ferr_cnt; o0 = ovr_cnt; g0 = got_cnt;
      if (vecs[v].stop_ok) exp_q.push_back(vecs[v].data);
      send_byte(vecs[v].data, vecs[v].per, vecs[v].stop_ok);
      if (!vecs[v].stop_ok) begin
        i_uart_rx = 1'b0;
        repeat (3 * DIV) @(posedge i_clk);
        #1;
        i_uart_rx = 1'b1;
      end
      repeat (DIV) @(posedge i_clk);
      #1;
      wait_drain($sformatf("vec%0d_drain", v));
      check($sformatf("vec%0d_bytes", v), got_cnt - g0, int'(vecs[v].stop_ok));
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
      if (vecs[v].chk_lat) begin
        check($sformatf("vec%0d_lat_ok", v),
              int'((rise_cyc - start_cyc >= EXP_LAT - 2) && (rise_cyc - start_cyc <= EXP_LAT + 2)), 1);
        check($sformatf("vec%0d_valid_len", v), last_run, 1);
      end
    end

    // Overrun: consumer stalls across two frames.
    f0 = ferr_cnt; o0 = ovr_cnt; g0 = got_cnt;
    bus.i_ready = 1'b0;
    exp_q.push_back(8'h41);
    send_byte(8'h41, DIV, 1'b1);
    send_byte(8'h42, DIV, 1'b1);
    repeat (DIV) @(posedge i_clk);
    #1;
    check("ovr_valid_held", int'(bus.o_valid), 1);
    check("ovr_data_held", int'(bus.o_data), 8'h41);
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_ferr", ferr_cnt - f0, 0);
    bus.i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("ovr_valid_drop", int'(bus.o_valid), 0);
    wait_drain("ovr_drain");
    check("ovr_bytes", got_cnt - g0, 1);

    // Short low glitch on an idle line, then a real frame.
    f0 = ferr_cnt; g0 = got_cnt;
    i_uart_rx = 1'b0;
    repeat (100) @(posedge i_clk);
    #1;
    i_uart_rx = 1'b1;
    repeat (2 * DIV) @(posedge i_clk);
    #1;
    check("glitch_bytes", got_cnt - g0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, DIV, 1'b1);
    repeat (DIV) @(posedge i_clk);
    #1;
    wait_drain("glitch_next_drain");
    check("glitch_next_bytes", got_cnt - g0, 1);

    // Reset in the middle of bit 4 of 0xC3.
    f0 = ferr_cnt; o0 = ovr_cnt; g0 = got_cnt;
    begin
      logic [7:0] b;
      b = 8'hC3;
      @(posedge i_clk);
      #1;
      drive_bit(1'b0, DIV);
      for (int i = 0; i < 4; i++) drive_bit(b[i], DIV);
      i_uart_rx = b[4];
      repeat (HALF) @(posedge i_clk);
      #1;
    end
    i_rst_n = 1'b0;
    i_uart_rx = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    check_idle_outputs("midframe_reset");
    i_rst_n = 1'b1;
    repeat (2 * DIV) @(posedge i_clk);
    #1;
    check_idle_outputs("after_release");
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, DIV, 1'b1);
    repeat (DIV) @(posedge i_clk);
    #1;
    wait_drain("rst_next_drain");
    check("rst_next_bytes", got_cnt - g0, 1);
    check("rst_ferr", ferr_cnt - f0, 0);
    check("rst_ovr", ovr_cnt - o0, 0);

    check("err_and_ovr_same_cycle", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
